// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch-stage controller.
// Fetch FSM states, redirect sources and PC step.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE,
    JUMP,
    BRANCH,
    TRAP
  } redirect_src_t;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority redirect select: trap > branch > jump.
// Misaligned branch/jump targets are turned into traps.
module pc_redirect_sel
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic            trap,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            hit,
  output logic [XLEN-1:0] target,
  output redirect_src_t   src,
  output logic            misalign
);

  always_comb begin
    hit      = 1'b1;
    target   = TRAP_VECTOR;
    src      = TRAP;
    misalign = 1'b0;
    priority case (1'b1)
      trap: ;
      branch: begin
        if (branch_target[1:0] != 2'b00) begin
          misalign = 1'b1;
        end else begin
          target = branch_target;
          src    = BRANCH;
        end
      end
      jump: begin
        if (jump_target[1:0] != 2'b00) begin
          misalign = 1'b1;
        end else begin
          target = jump_target;
          src    = JUMP;
        end
      end
      default: begin
        hit = 1'b0;
        src = NONE;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner and imem request sequencer.
// Optional perf counters under PC_FETCH_PERF_EN.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            trap_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            if_valid_o,
  output logic            flush_if_o,
  output logic            flush_id_o,
  output logic            misalign_o
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_redirect_cnt_o
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tgt;
  redirect_src_t   src;
  logic            hit;
  logic            mis;
  logic            redir;
  logic            consume;

  pc_redirect_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_sel (
    .trap          (trap_i),
    .branch        (branch_taken_i),
    .branch_target (branch_target_i),
    .jump          (jump_i),
    .jump_target   (jump_target_i),
    .hit           (hit),
    .target        (tgt),
    .src           (src),
    .misalign      (mis)
  );

  // Redirects are ignored in IDLE and while reset is held.
  assign redir   = hit && !reset && (state != IDLE);
  assign consume = (state == HOLD) && !redir && !stall_i;

  assign flush_if_o  = redir;
  assign flush_id_o  = redir && (src != JUMP);
  assign pc_o        = pc;
  assign imem_addr_o = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      instr_o    <= '0;
      if_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      imem_req_o <= 1'b0;
    end else begin
      misalign_o <= redir && mis;
      if (redir) begin
        pc         <= tgt;
        if_valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          state      <= REQ;
          imem_req_o <= 1'b1;
        end
        REQ: begin
          if (redir) begin
            state      <= imem_ready_i ? DROP : REQ;
            imem_req_o <= !imem_ready_i;
          end else if (imem_ready_i) begin
            state      <= WAIT;
            imem_req_o <= 1'b0;
          end
        end
        WAIT: begin
          if (redir) begin
            state <= DROP;
          end else if (imem_valid_i) begin
            instr_o    <= imem_rdata_i;
            if_valid_o <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (redir) begin
            state      <= REQ;
            imem_req_o <= 1'b1;
          end else if (!stall_i) begin
            pc         <= pc + XLEN'(PC_INCR);
            if_valid_o <= 1'b0;
            state      <= REQ;
            imem_req_o <= 1'b1;
          end
        end
        DROP: begin
          // The stale response retires the drop even if redirected again.
          if (imem_valid_i) begin
            state      <= REQ;
            imem_req_o <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt_o    <= '0;
      perf_redirect_cnt_o <= '0;
    end else begin
      if (consume) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (redir) perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl.
// Fetches pushed on request, popped when if_valid_o rises.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        trap_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        if_valid_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        misalign_o;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_redirect_cnt_o;
`endif

  pc_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .trap_i          (trap_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_valid_i    (imem_valid_i),
    .imem_rdata_i    (imem_rdata_i),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .if_valid_o      (if_valid_o),
    .flush_if_o      (flush_if_o),
    .flush_id_o      (flush_id_o),
    .misalign_o      (misalign_o)
`ifdef PC_FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o    (perf_fetch_cnt_o),
    .perf_redirect_cnt_o (perf_redirect_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        vld_q  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0050_0093 ^ a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: each new valid fetch must match the oldest request.
  always @(negedge clk) begin
    if (!reset && if_valid_o && !vld_q) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fetch_pc", pc_o, e.pc);
        chk("fetch_ins", instr_o, e.ins);
      end
    end
    vld_q = if_valid_o && !reset;
  end

  task automatic fetch_to_hold(input int nwait);
    chk("req", 32'(imem_req_o), 32'd1);
    chk("addr", imem_addr_o, exp_pc);
    exp_q.push_back('{exp_pc, mem(exp_pc)});
    repeat (nwait) begin
      tick();
      chk("addr_hold", imem_addr_o, exp_pc);
      chk("req_hold", 32'(imem_req_o), 32'd1);
    end
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    chk("wait_req", 32'(imem_req_o), 32'd0);
    chk("wait_vld", 32'(if_valid_o), 32'd0);
    imem_valid_i = 1'b1;
    imem_rdata_i = mem(exp_pc);
    tick();
    imem_valid_i = 1'b0;
    imem_rdata_i = $urandom;
    chk("if_valid", 32'(if_valid_o), 32'd1);
  endtask

  task automatic consume(input int n);
    stall_i = 1'b1;
    repeat (n) begin
      tick();
      chk("st_pc", pc_o, exp_pc);
      chk("st_ins", instr_o, mem(exp_pc));
      chk("st_req", 32'(imem_req_o), 32'd0);
      chk("st_vld", 32'(if_valid_o), 32'd1);
    end
    stall_i = 1'b0;
    tick();
    exp_pc = exp_pc + 32'd4;
    chk("nxt_addr", imem_addr_o, exp_pc);
    chk("nxt_req", 32'(imem_req_o), 32'd1);
    chk("nxt_vld", 32'(if_valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    stall_i         = 1'b0;
    jump_i          = 1'b0;
    jump_target_i   = '0;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    trap_i          = 1'b1;
    imem_ready_i    = 1'b0;
    imem_valid_i    = 1'b0;
    imem_rdata_i    = '0;
    tick();
    tick();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_vld", 32'(if_valid_o), 32'd0);
    chk("rst_ins", instr_o, 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_fif", 32'(flush_if_o), 32'd0);
    chk("rst_fid", 32'(flush_id_o), 32'd0);
    trap_i = 1'b0;
    reset  = 1'b0;
    // Stray valid in IDLE must be ignored.
    imem_valid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_valid_i = 1'b0;
    chk("idle_vld", 32'(if_valid_o), 32'd0);
    exp_pc = 32'h0;

    fetch_to_hold(0);
    consume(0);
    fetch_to_hold(2);
    consume(3);

    // Taken branch while waiting: flush both, drop stale word.
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i    = 1'b0;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h40;
    #1;
    chk("br_fif", 32'(flush_if_o), 32'd1);
    chk("br_fid", 32'(flush_id_o), 32'd1);
    tick();
    branch_taken_i = 1'b0;
    chk("br_pc", pc_o, 32'h40);
    chk("drop_req", 32'(imem_req_o), 32'd0);
    imem_valid_i = 1'b1;
    imem_rdata_i = 32'hBAD0_0BAD;
    tick();
    imem_valid_i = 1'b0;
    chk("drop_vld", 32'(if_valid_o), 32'd0);
    exp_pc = 32'h40;
    fetch_to_hold(0);
    consume(0);

    // All three sources at once: trap wins.
    trap_i          = 1'b1;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h80;
    jump_i          = 1'b1;
    jump_target_i   = 32'h90;
    #1;
    chk("tr_fif", 32'(flush_if_o), 32'd1);
    chk("tr_fid", 32'(flush_id_o), 32'd1);
    tick();
    trap_i         = 1'b0;
    branch_taken_i = 1'b0;
    jump_i         = 1'b0;
    chk("tr_addr", imem_addr_o, 32'h100);
    chk("tr_mis", 32'(misalign_o), 32'd0);

    // Aligned jump flushes IF only.
    jump_i        = 1'b1;
    jump_target_i = 32'h200;
    #1;
    chk("jp_fif", 32'(flush_if_o), 32'd1);
    chk("jp_fid", 32'(flush_id_o), 32'd0);
    tick();
    chk("jp_addr", imem_addr_o, 32'h200);

    // Misaligned jump becomes a trap.
    jump_target_i = 32'h42;
    #1;
    chk("mj_fif", 32'(flush_if_o), 32'd1);
    chk("mj_fid", 32'(flush_id_o), 32'd1);
    tick();
    jump_i = 1'b0;
    chk("mj_pc", pc_o, 32'h100);
    chk("mj_mis1", 32'(misalign_o), 32'd1);
    tick();
    chk("mj_mis0", 32'(misalign_o), 32'd0);
    exp_pc = 32'h100;

    // Redirect from HOLD overrides stall.
    fetch_to_hold(0);
    stall_i       = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = 32'hFFFF_FFFC;
    #1;
    chk("hj_fid", 32'(flush_id_o), 32'd0);
    tick();
    jump_i  = 1'b0;
    stall_i = 1'b0;
    chk("hj_vld", 32'(if_valid_o), 32'd0);
    chk("hj_req", 32'(imem_req_o), 32'd1);
    exp_pc = 32'hFFFF_FFFC;
    fetch_to_hold(1);
    consume(1);
    chk("wrap", imem_addr_o, 32'h0);

    // Reset in WAIT; the late response is ignored.
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_pc", pc_o, 32'h0);
    chk("rw_req", 32'(imem_req_o), 32'd0);
    imem_valid_i = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    tick();
    imem_valid_i = 1'b0;
    chk("rw_vld", 32'(if_valid_o), 32'd0);
    chk("rw_ins", instr_o, 32'h0);
    exp_pc = 32'h0;
`ifdef PC_FETCH_PERF_EN
    chk("perf_clr", perf_fetch_cnt_o, 32'd0);
`endif
    fetch_to_hold(0);
    consume(0);
`ifdef PC_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt_o, 32'd1);
    chk("perf_redir", perf_redirect_cnt_o, 32'd0);
`endif
    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-stage controller that owns the program counter register and sequences instruction fetches over a request/valid handshake to instruction memory. Selects the next PC from sequential, jump (ID), branch (EX) and trap sources. Holds the fetched instruction under hazard stall and issues IF/ID flush pulses on redirect. Sits between the hazard/branch logic and the IF/ID pipeline register of the 5-stage core.

Parameters:
XLEN, 32, datapath and PC width
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high reset
stall_i  in  1  hazard-unit stall; IF instruction must not be consumed
jump_i  in  1  jump resolved in ID
jump_target_i  in  XLEN  jump destination
branch_taken_i  in  1  taken branch resolved in EX
branch_target_i  in  XLEN  branch destination
trap_i  in  1  trap request
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address (= pc_o)
imem_ready_i  in  1  imem accepts request this cycle
imem_valid_i  in  1  imem returns data this cycle
imem_rdata_i  in  32  returned instruction
pc_o  out  XLEN  current fetch PC
instr_o  out  32  held instruction
if_valid_o  out  1  instr_o/pc_o valid for ID
flush_if_o  out  1  kill IF/ID contents
flush_id_o  out  1  kill ID/EX contents
misalign_o  out  1  one-cycle pulse: misaligned redirect target

Behaviour:
- Reset (reset high at clk edge): state=IDLE, pc=RESET_VECTOR, instr_o=0, if_valid_o=0, misalign_o=0, imem_req_o=0; flush outputs forced 0 while reset high.
- States: IDLE, REQ, WAIT, HOLD, DROP. IDLE -> REQ unconditionally next cycle; imem_valid_i ignored in IDLE.
- REQ: imem_req_o=1, imem_addr_o=pc. imem_ready_i=1 -> WAIT; else stay REQ (address stable).
- WAIT: imem_req_o=0. imem_valid_i=1 -> capture imem_rdata_i into instr_o, -> HOLD.
- HOLD: if_valid_o=1. stall_i=0 -> instruction consumed, pc<=pc+4, -> REQ. stall_i=1 -> stay, pc/instr_o held.
- Min throughput: ready in REQ, valid next cycle -> if_valid_o 2 cycles after request, 3 cycles/instr.
- Redirect (combinational select, priority trap > branch > jump) in any state except IDLE: pc<=target, if_valid_o<=0, stall_i ignored. From REQ accepted this cycle or from WAIT -> DROP; from REQ not accepted or HOLD -> REQ.
- DROP: discard next imem_valid_i, then -> REQ; a redirect in DROP updates pc and stays DROP.
- Flush (combinational, same cycle as redirect): trap -> both; branch -> both; jump only -> flush_if_o.
- Target with bits[1:0]!=0 (branch/jump): treated as trap; pc<=TRAP_VECTOR, misalign_o pulses next cycle, both flushes asserted.
- PC arithmetic modulo 2^XLEN: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- Reset mid-operation overrides everything; outstanding imem responses after reset are ignored.

Optional Feature:
PC_FETCH_PERF_EN: defined -> adds outputs perf_fetch_cnt_o and perf_redirect_cnt_o (32 bits each). Fetch count increments on each HOLD consume; redirect count increments on each redirect. Both clear on reset and wrap at 2^32. Undefined -> ports and counters absent; all other behaviour identical.

Decomposition:
- Package pc_fetch_pkg: fetch_state_t enum (IDLE, REQ, WAIT, HOLD, DROP), redirect_src_t enum (NONE, JUMP, BRANCH, TRAP), PC_INCR=4 constant.
- Sub-module pc_redirect_sel: combinational priority select producing target, source and misalign flag. Top holds the FSM and registers.

Test Plan:
- Reset then imem_ready_i=1, valid 1 cycle later, rdata=32'h00500093 -> imem_addr_o=0, if_valid_o at cycle 3, pc_o=0; next request addr=4.
- HOLD with stall_i=1 for 3 cycles -> pc_o/instr_o held, no imem_req_o; stall drops -> next addr=pc+4.
- branch_taken_i with target 32'h40 in WAIT -> flush_if_o=flush_id_o=1 same cycle; next returned word dropped; next request addr=32'h40.
- trap_i, branch_taken_i and jump_i together -> pc=TRAP_VECTOR, both flushes asserted.
- jump_target_i=32'h42 -> pc=32'h100, misalign_o pulse 1 cycle.
- pc=32'hFFFF_FFFC consumed -> next addr 0; reset asserted in WAIT -> IDLE, late imem_valid_i ignored, pc=RESET_VECTOR.
